// File: rtl/skew_tile_buf.sv
// Double-buffered DIMxDIM operand tile that streams the committed bank as a
// diagonally skewed wavefront (lane r lags r beats), optionally transposed.
module skew_tile_buf #(
    parameter int BITS_AB = 8,
    parameter int DIM     = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     wr_en,
    input  logic [$clog2(DIM)-1:0]   wr_row,
    input  logic [BITS_AB*DIM-1:0]   wr_data,
    input  logic                     wr_commit,
    output logic                     wr_ready,
    input  logic                     start,
    input  logic                     transpose,
    input  logic                     en,
    output logic                     rd_ready,
    output logic                     busy,
    output logic                     out_valid,
    output logic                     out_last,
    output logic [BITS_AB*DIM-1:0]   Aout
);

    localparam int ROW_W  = $clog2(DIM);
    localparam int T_W    = $clog2(2*DIM-1);
    localparam int ROW_BITS = BITS_AB*DIM;
    localparam logic [T_W-1:0] LAST_T = T_W'(2*DIM-2);

    typedef enum logic {IDLE, STREAM} state_t;

    state_t              state;
    logic                rd_sel;
    logic [1:0]          full;
    logic [T_W-1:0]      t;
    logic                tmode;
    logic [ROW_BITS-1:0] lanes;
    logic                swap;

    logic [ROW_BITS-1:0] mem [2][DIM];

    assign wr_ready = ~full[~rd_sel];
    assign rd_ready = (state == IDLE) && full[rd_sel];
    assign busy     = (state == STREAM);
    assign swap     = (state == IDLE) && !full[rd_sel] && full[~rd_sel];

    // NOTE: the tile storage carries no reset; its contents are don't-care
    // until written, and leaving it out keeps the array mappable to RAM.
    always_ff @(posedge clk) begin
        if (wr_en && wr_ready)
            mem[~rd_sel][wr_row] <= wr_data;
    end

    // Lane r shows element k = t - r of its row (or column when transposed);
    // lanes whose k falls outside the tile stay at zero.
    always_comb begin
        lanes = '0;
        for (int r = 0; r < DIM; r++) begin
            for (int k = 0; k < DIM; k++) begin
                if (int'(t) == r + k) begin
                    if (tmode)
                        lanes[r*BITS_AB +: BITS_AB] = mem[rd_sel][ROW_W'(k)][r*BITS_AB +: BITS_AB];
                    else
                        lanes[r*BITS_AB +: BITS_AB] = mem[rd_sel][ROW_W'(r)][k*BITS_AB +: BITS_AB];
                end
            end
        end
    end

    // NOTE: every register below uses non-blocking assignment so all of them
    // see the pre-edge values of full/rd_sel/t within the same clock.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            rd_sel    <= 1'b0;
            full      <= 2'b00;
            t         <= '0;
            tmode     <= 1'b0;
            Aout      <= '0;
            out_valid <= 1'b0;
            out_last  <= 1'b0;
        end else begin
            if (wr_commit && wr_ready)
                full[~rd_sel] <= 1'b1;

            case (state)
                IDLE: begin
                    Aout      <= '0;
                    out_valid <= 1'b0;
                    out_last  <= 1'b0;
                    if (swap) begin
                        rd_sel <= ~rd_sel;
                    end else if (start && full[rd_sel]) begin
                        tmode <= transpose;
                        t     <= '0;
                        state <= STREAM;
                    end
                end
                STREAM: begin
                    if (en) begin
                        Aout      <= lanes;
                        out_valid <= 1'b1;
                        out_last  <= (t == LAST_T);
                        if (t == LAST_T) begin
                            full[rd_sel] <= 1'b0;
                            t            <= '0;
                            state        <= IDLE;
                        end else begin
                            t <= t + 1'b1;
                        end
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_skew_tile_buf.sv
// Self-checking bench for skew_tile_buf (DIM=4, BITS_AB=8): directed scenarios
// plus randomized traffic, all checked every cycle against a tile-level model.
module tb_skew_tile_buf;

    localparam int B     = 8;
    localparam int DIM   = 4;
    localparam int W     = B*DIM;
    localparam int ROW_W = $clog2(DIM);
    localparam int NB    = 2*DIM-1;

    typedef logic [B-1:0] tile_t [DIM][DIM];

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             wr_en = 1'b0;
    logic [ROW_W-1:0] wr_row = '0;
    logic [W-1:0]     wr_data = '0;
    logic             wr_commit = 1'b0;
    logic             wr_ready;
    logic             start = 1'b0;
    logic             transpose = 1'b0;
    logic             en = 1'b1;
    logic             rd_ready;
    logic             busy;
    logic             out_valid;
    logic             out_last;
    logic [W-1:0]     Aout;

    skew_tile_buf #(.BITS_AB(B), .DIM(DIM)) dut (
        .clk(clk), .rst(rst), .wr_en(wr_en), .wr_row(wr_row), .wr_data(wr_data),
        .wr_commit(wr_commit), .wr_ready(wr_ready), .start(start),
        .transpose(transpose), .en(en), .rd_ready(rd_ready), .busy(busy),
        .out_valid(out_valid), .out_last(out_last), .Aout(Aout)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;
    bit chk_on   = 1'b0;

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, got, exp, $time);
        end
    endtask

    // Wavefront beat t of tile a: lane r carries a[r][t-r] (or a[t-r][r]).
    function automatic logic [W-1:0] beat_of(input tile_t a, input int t, input logic tr);
        logic [W-1:0] v = '0;
        for (int r = 0; r < DIM; r++) begin
            int c = t - r;
            if (c >= 0 && c < DIM)
                v[r*B +: B] = tr ? a[c][r] : a[r][c];
        end
        return v;
    endfunction

    // ---------------- tile-level reference model ----------------
    tile_t        m_mem [2];
    bit           m_full [2];
    int           m_rd;
    bit           m_strm;
    int           m_idx;
    logic [W-1:0] m_beats [NB];
    logic [W-1:0] exp_aout;
    logic         exp_valid;
    logic         exp_last;

    always @(posedge clk or posedge rst) begin
        int  wb;
        bit  wr_ok;
        bit  commit_ok;
        if (rst) begin
            m_full[0] = 0; m_full[1] = 0;
            m_rd = 0; m_strm = 0; m_idx = 0;
            exp_aout = '0; exp_valid = 0; exp_last = 0;
        end else begin
            wb        = 1 - m_rd;
            wr_ok     = !m_full[wb];
            commit_ok = wr_commit && wr_ok;
            if (wr_en && wr_ok)
                for (int c = 0; c < DIM; c++)
                    m_mem[wb][wr_row][c] = wr_data[c*B +: B];
            if (m_strm) begin
                if (en) begin
                    exp_aout  = m_beats[m_idx];
                    exp_valid = 1;
                    exp_last  = (m_idx == NB-1);
                    if (exp_last) begin
                        m_full[m_rd] = 0;
                        m_strm = 0;
                    end else begin
                        m_idx++;
                    end
                end
            end else begin
                exp_aout = '0; exp_valid = 0; exp_last = 0;
                if (!m_full[m_rd] && m_full[wb]) begin
                    m_rd = wb;
                end else if (start && m_full[m_rd]) begin
                    for (int k = 0; k < NB; k++)
                        m_beats[k] = beat_of(m_mem[m_rd], k, transpose);
                    m_strm = 1;
                    m_idx  = 0;
                end
            end
            if (commit_ok)
                m_full[wb] = 1;
        end
    end

    always @(negedge clk) begin
        if (chk_on && !rst) begin
            check("aout",      Aout,      exp_aout);
            check("out_valid", out_valid, exp_valid);
            check("out_last",  out_last,  exp_last);
            check("busy",      busy,      m_strm);
            check("rd_ready",  rd_ready,  !m_strm && m_full[m_rd]);
            check("wr_ready",  wr_ready,  !m_full[1-m_rd]);
        end
    end

    // ---------------- stimulus helpers ----------------
    logic [W-1:0] cap [$];
    logic         cap_last [$];

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic write_row(input int r, input logic [W-1:0] d);
        wr_en = 1'b1; wr_row = ROW_W'(r); wr_data = d;
        @(negedge clk);
        wr_en = 1'b0;
    endtask

    // kind 0: 16r+c, kind 1: all -1, kind 2: 0x40+4r+c
    function automatic logic [W-1:0] tile_row(input int kind, input int r);
        logic [W-1:0] d = '0;
        for (int c = 0; c < DIM; c++)
            d[c*B +: B] = (kind == 0) ? B'(16*r + c) : (kind == 1) ? 8'hFF : B'(8'h40 + 4*r + c);
        return d;
    endfunction

    task automatic load_tile(input int kind);
        for (int r = 0; r < DIM; r++) write_row(r, tile_row(kind, r));
    endtask

    task automatic commit();
        wr_commit = 1'b1;
        @(negedge clk);
        wr_commit = 1'b0;
    endtask

    // Starts a stream, captures each new beat, optionally stalls after beat
    // stall_at and pulses a redundant start while busy.
    task automatic run_stream(input logic tr, input int stall_at, input int stall_len, input bit again);
        int beats = 0;
        int cyc = 0;
        int stalled = 0;
        logic prev_en;
        cap.delete(); cap_last.delete();
        transpose = tr; start = 1'b1; en = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check("busy_after_start", busy, 1'b1);
        while (beats < NB && cyc < 60) begin
            prev_en = en;
            @(negedge clk);
            cyc++;
            if (prev_en && out_valid) begin
                cap.push_back(Aout);
                cap_last.push_back(out_last);
                beats++;
            end else if (!prev_en && cap.size() > 0) begin
                check("stall_hold_aout", Aout, cap[$]);
                check("stall_hold_last", out_last, cap_last[$]);
            end
            start = (again && cyc == 2);
            if (stall_at >= 0 && beats == stall_at + 1 && stalled < stall_len) begin
                en = 1'b0; stalled++;
            end else begin
                en = 1'b1;
            end
        end
        start = 1'b0; en = 1'b1;
        check("beat_count", beats, NB);
    endtask

    // ---------------- test sequence ----------------
    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        tile_t ta;
        for (int r = 0; r < DIM; r++)
            for (int c = 0; c < DIM; c++) ta[r][c] = B'(16*r + c);

        // Pin the model's wavefront rule to hand-computed values.
        check("model_n3", beat_of(ta, 3, 0), 32'h30211203);
        check("model_t1", beat_of(ta, 1, 1), 32'h00000110);
        check("model_n6", beat_of(ta, 6, 0), 32'h33000000);

        tick(3);
        check("rst_aout",     Aout,      '0);
        check("rst_valid",    out_valid, 1'b0);
        check("rst_last",     out_last,  1'b0);
        check("rst_busy",     busy,      1'b0);
        check("rst_rd_ready", rd_ready,  1'b0);
        check("rst_wr_ready", wr_ready,  1'b1);
        rst = 1'b0;
        chk_on = 1'b1;

        // Normal stream with commit-to-readable timing.
        load_tile(0);
        commit();
        check("commit_wr_ready0", wr_ready, 1'b0);
        check("commit_rd_ready0", rd_ready, 1'b0);
        tick(1);
        check("commit_rd_ready1", rd_ready, 1'b1);
        check("commit_wr_ready1", wr_ready, 1'b1);
        run_stream(1'b0, -1, 0, 1'b0);
        check("n_beat0", cap[0], 32'h00000000);
        check("n_beat3", cap[3], 32'h30211203);
        check("n_beat6", cap[6], 32'h33000000);
        for (int i = 0; i < NB; i++) check("n_last", cap_last[i], (i == NB-1));
        tick(1);
        check("valid_drop", out_valid, 1'b0);

        // Transposed stream.
        load_tile(0);
        commit();
        tick(1);
        run_stream(1'b1, -1, 0, 1'b0);
        check("t_beat1", cap[1], 32'h00000110);
        check("t_beat3", cap[3], 32'h03122130);

        // Ping-pong: tile B written and committed while A streams.
        load_tile(0);
        commit();
        tick(1);
        fork
            run_stream(1'b0, -1, 0, 1'b0);
            begin
                for (int r = 0; r < DIM; r++) begin
                    check("pp_wr_ready", wr_ready, 1'b1);
                    write_row(r, tile_row(1, r));
                end
                check("pp_wr_ready", wr_ready, 1'b1);
                commit();
            end
        join
        check("pp_a_last", out_last, 1'b1);
        check("pp_rd_ready_at_last", rd_ready, 1'b0);
        tick(1);
        check("pp_rd_ready_next", rd_ready, 1'b1);
        run_stream(1'b0, -1, 0, 1'b0);
        check("pp_b_beat0", cap[0], 32'h000000FF);
        check("pp_b_beat3", cap[3], 32'hFFFFFFFF);
        check("pp_b_beat6", cap[6], 32'hFF000000);

        // Stall for 3 cycles at beat 2.
        load_tile(0);
        commit();
        tick(1);
        run_stream(1'b0, 2, 3, 1'b0);
        check("st_beat3", cap[3], 32'h30211203);
        check("st_beat6", cap[6], 32'h33000000);

        // Both banks full: stray write ignored, second start ignored.
        load_tile(0);
        commit();
        tick(1);
        load_tile(2);
        commit();
        check("bf_wr_ready", wr_ready, 1'b0);
        write_row(0, 32'h55555555);
        run_stream(1'b0, -1, 0, 1'b1);
        check("bf_a_beat3", cap[3], 32'h30211203);
        tick(1);
        run_stream(1'b0, -1, 0, 1'b0);
        check("bf_c_beat0", cap[0], 32'h00000040);
        check("bf_c_beat3", cap[3], 32'h4C494643);

        // Asynchronous reset at beat 4, then a clean stream.
        load_tile(0);
        commit();
        tick(1);
        start = 1'b1; en = 1'b1;
        @(negedge clk);
        start = 1'b0;
        tick(5);
        check("pre_rst_valid", out_valid, 1'b1);
        #2 rst = 1'b1;
        #1;
        check("arst_aout",     Aout,      '0);
        check("arst_valid",    out_valid, 1'b0);
        check("arst_last",     out_last,  1'b0);
        check("arst_busy",     busy,      1'b0);
        check("arst_rd_ready", rd_ready,  1'b0);
        check("arst_wr_ready", wr_ready,  1'b1);
        @(negedge clk);
        rst = 1'b0;
        load_tile(0);
        commit();
        tick(1);
        run_stream(1'b0, -1, 0, 1'b0);
        check("post_rst_beat0", cap[0], 32'h00000000);
        check("post_rst_beat3", cap[3], 32'h30211203);

        // Randomized traffic checked every cycle by the model.
        for (int i = 0; i < 3000; i++) begin
            if (i % 1000 == 500) begin
                wr_en = 1'b0; wr_commit = 1'b0; start = 1'b0;
                rst = 1'b1;
                @(negedge clk);
                rst = 1'b0;
            end
            wr_en     = ($urandom_range(0, 1) == 1);
            wr_row    = ROW_W'($urandom_range(0, DIM-1));
            wr_data   = W'($urandom);
            wr_commit = ($urandom_range(0, 7) == 0);
            start     = ($urandom_range(0, 3) == 0);
            transpose = 1'($urandom_range(0, 1));
            en        = ($urandom_range(0, 3) != 0);
            @(negedge clk);
        end
        wr_en = 1'b0; wr_commit = 1'b0; start = 1'b0; en = 1'b1;
        tick(2);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
